// File: rtl/gf2m_mul_alu.sv
// ---------------------------------------------------------------------------
// gf2m_mul_alu
//   Small GF(2^M) arithmetic unit built around one result/accumulator
//   register. Single-cycle STO, ADD (XOR) and MULX (multiply by x, reduced).
//   MUL is a bit-serial, MSB-first shift-and-add multiplier that takes M
//   cycles.
//
// Parameters
//   M     field degree (M >= 2)
//   POLY  reduction polynomial without the x^M term (bit 0 must be set)
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset
//   start  in   operation request, only taken while busy = 0
//   op     in   00 STO, 01 ADD, 10 MULX, 11 MUL
//   sbus   in   M-bit first operand
//   tbus   in   M-bit second operand (MUL only)
//   dbus   out  registered result / accumulator
//   busy   out  high while a MUL is in progress
//   done   out  one-cycle pulse, result of the last accepted op on dbus
//   mz     out  registered MSB of the last STO/ADD/MULX sbus operand
//   eq     out  combinational, high when dbus == 0
// ---------------------------------------------------------------------------
module gf2m_mul_alu #(
    parameter int unsigned M    = 163,
    parameter logic [M-1:0] POLY = 'hC9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [M-1:0] sbus,
    input  logic [M-1:0] tbus,
    output logic [M-1:0] dbus,
    output logic         busy,
    output logic         done,
    output logic         mz,
    output logic         eq
);

    localparam int unsigned CW = $clog2(M);

    typedef enum logic [1:0] {
        OP_STO  = 2'b00,
        OP_ADD  = 2'b01,
        OP_MULX = 2'b10,
        OP_MUL  = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e          state_q;
    logic [M-1:0]    dbus_q;
    logic [M-1:0]    a_q;
    logic [M-1:0]    b_q;
    logic [M-1:0]    c_q;
    logic [CW-1:0]   cnt_q;
    logic            done_q;
    logic            mz_q;

    logic [M-1:0]    c_d;
    logic [M-1:0]    mulx_s_d;

    // Multiply by x followed by one conditional reduction step.
    function automatic logic [M-1:0] mulx(input logic [M-1:0] v);
        return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY : '0);
    endfunction

    // One MSB-first iteration of the serial multiplier.
    always_comb begin
        c_d      = mulx(c_q) ^ (b_q[cnt_q] ? a_q : '0);
        mulx_s_d = mulx(sbus);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            dbus_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            mz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (op_e'(op))
                            OP_STO: begin
                                dbus_q <= sbus;
                                mz_q   <= sbus[M-1];
                                done_q <= 1'b1;
                            end
                            OP_ADD: begin
                                dbus_q <= dbus_q ^ sbus;
                                mz_q   <= sbus[M-1];
                                done_q <= 1'b1;
                            end
                            OP_MULX: begin
                                dbus_q <= mulx_s_d;
                                mz_q   <= sbus[M-1];
                                done_q <= 1'b1;
                            end
                            default: begin
                                a_q     <= sbus;
                                b_q     <= tbus;
                                c_q     <= '0;
                                cnt_q   <= CW'(M - 1);
                                state_q <= S_RUN;
                            end
                        endcase
                    end
                end
                default: begin
                    // The i = 0 iteration writes straight to dbus so the
                    // result lands exactly M edges after the accept.
                    if (cnt_q == '0) begin
                        dbus_q  <= c_d;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        c_q   <= c_d;
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
            endcase
        end
    end

    assign dbus = dbus_q;
    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign mz   = mz_q;
    assign eq   = (dbus_q == '0);

endmodule

// File: tb/tb_gf2m_mul_alu.sv
module tb_gf2m_mul_alu;

    localparam int unsigned M = 8;
    localparam logic [7:0] POLY = 8'h1B;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] sbus = '0;
    logic [7:0] tbus = '0;
    logic [7:0] dbus;
    logic       busy;
    logic       done;
    logic       mz;
    logic       eq;

    int unsigned passed = 0;
    int unsigned total  = 0;

    logic [7:0] acc;
    logic       mz_m;

    gf2m_mul_alu #(.M(M), .POLY(POLY)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .sbus  (sbus),
        .tbus  (tbus),
        .dbus  (dbus),
        .busy  (busy),
        .done  (done),
        .mz    (mz),
        .eq    (eq)
    );

    always #5 clk = ~clk;

    // Reference: carry-less polynomial product, then reduce modulo x^8 + POLY.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        logic [15:0] modp;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int d = 14; d >= 8; d--) begin
            modp = {7'b0, 1'b1, POLY} << (d - 8);
            if (p[d]) p = p ^ modp;
        end
        return p[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single_op(input logic [1:0] o, input logic [7:0] s);
        start = 1'b1;
        op    = o;
        sbus  = s;
        tick();
        start = 1'b0;
        case (o)
            2'b00: acc = s;
            2'b01: acc = acc ^ s;
            default: acc = ref_mul(s, 8'h02);
        endcase
        mz_m = s[7];
        check("op_dbus", dbus, acc);
        check("op_done", done, 1'b1);
        check("op_mz", mz, mz_m);
        check("op_eq", eq, acc == 8'h00);
        check("op_busy", busy, 1'b0);
    endtask

    // Called right after the accepting edge of a MUL; returns in the done cycle.
    task automatic mul_wait(input logic [7:0] exp, input bit inject);
        logic [7:0]  prev;
        int unsigned bcnt;
        int unsigned n;
        bit          hold_ok;
        prev    = dbus;
        bcnt    = 0;
        n       = 0;
        hold_ok = 1'b1;
        while (busy && n < 40) begin
            bcnt++;
            if (dbus !== prev || done !== 1'b0) hold_ok = 1'b0;
            start = inject;
            op    = 2'b00;
            sbus  = inject ? 8'hFF : 8'($urandom);
            tbus  = 8'($urandom);
            tick();
            n++;
        end
        start = 1'b0;
        check("mul_busy_cycles", bcnt, M);
        check("mul_hold", hold_ok, 1'b1);
        check("mul_done", done, 1'b1);
        check("mul_dbus", dbus, exp);
        check("mul_mz_kept", mz, mz_m);
        acc = exp;
    endtask

    task automatic mul_start(input logic [7:0] a, input logic [7:0] b);
        start = 1'b1;
        op    = 2'b11;
        sbus  = a;
        tbus  = b;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [1:0] ro;

        acc  = '0;
        mz_m = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_dbus", dbus, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_mz", mz, 1'b0);
        check("rst_eq", eq, 1'b1);

        // STO then ADD of the same value
        single_op(2'b00, 8'h57);
        check("sto_57", dbus, 8'h57);
        single_op(2'b01, 8'h57);
        check("add_zero_eq", eq, 1'b1);
        tick();
        check("idle_done", done, 1'b0);
        check("idle_hold", dbus, 8'h00);

        // MULX
        single_op(2'b10, 8'h57);
        check("mulx_57", dbus, 8'hAE);
        check("mulx_57_mz", mz, 1'b0);
        single_op(2'b10, 8'h80);
        check("mulx_80", dbus, 8'h1B);
        check("mulx_80_mz", mz, 1'b1);
        tick();

        // MUL directed, with STO 0xFF injected during the first run
        mul_start(8'h57, 8'h83);
        check("mul_busy_first", busy, 1'b1);
        mul_wait(8'hC1, 1'b1);
        tick();
        check("mul_single_done", done, 1'b0);
        check("mul_after_inject", dbus, 8'hC1);
        mul_start(8'h57, 8'h13);
        mul_wait(8'hFE, 1'b0);

        // MUL accepted in the done cycle of the previous MUL
        mul_start(8'hA5, 8'h3C);
        check("chain_busy_gap", busy, 1'b1);
        mul_wait(ref_mul(8'hA5, 8'h3C), 1'b0);
        mul_start(8'h02, 8'h80);
        check("chain2_busy", busy, 1'b1);
        mul_wait(8'h1B, 1'b0);
        tick();

        // Reset mid-run aborts with no done pulse
        mul_start(8'h57, 8'h83);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_dbus", dbus, 8'h00);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_eq", eq, 1'b1);
        mz_m = 1'b0;
        acc  = 8'h00;
        single_op(2'b00, 8'h01);
        check("post_abort_sto", dbus, 8'h01);
        tick();
        check("post_abort_quiet", done, 1'b0);

        // Randomised operation mix against the reference
        for (int k = 0; k < 60; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            ro = 2'($urandom);
            if (ro == 2'b11) begin
                mul_start(ra, rb);
                mul_wait(ref_mul(ra, rb), 1'($urandom));
            end else begin
                single_op(ro, ra);
            end
            if ($urandom_range(0, 2) == 0) begin
                sbus = 8'($urandom);
                tbus = 8'($urandom);
                tick();
                check("rand_idle_done", done, 1'b0);
                check("rand_idle_dbus", dbus, acc);
                check("rand_idle_mz", mz, mz_m);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
